// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the spin-echo / CPMG pulse sequencer.
// State encoding, field widths and the power-on timing defaults live here.
package pulse_seq_pkg;

    localparam int PER_W = 32;
    localparam int T_W   = 16;
    localparam int CP_W  = 8;
    localparam int TMR_W = T_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        GAP,
        P2,
        ECHO,
        HOLD,
        TAIL
    } seq_state_t;

    localparam logic [PER_W-1:0] PER_RST   = 32'd10000;
    localparam logic [T_W-1:0]   P1WID_RST = 16'd40;
    localparam logic [T_W-1:0]   DEL_RST   = 16'd150;
    localparam logic [T_W-1:0]   P2WID_RST = 16'd40;
    localparam logic [CP_W-1:0]  CP_RST    = 8'd1;
    localparam logic [7:0]       PBL_RST   = 8'd100;
    localparam logic             BL_RST    = 1'b1;

endpackage

// File: rtl/pulse_sequencer_timer.sv
// seq_timer: loadable down counter shared by every timed sequencer state.
// Latency: a value loaded at an edge reads back in the next cycle; done is combinational.
// Backpressure: none, it counts every cycle until it reaches zero.
module seq_timer
    import pulse_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] val,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A state loaded with N lasts N cycles: done fires while the count shows 1.
    assign done = (cnt <= TMR_W'(1));

endmodule

// File: rtl/pulse_sequencer.sv
// Spin-echo / CPMG pulse train generator with blanking gate and per-period sync; shadowed timing.
// Latency: pulse rises one cycle after the sync strobe; updates land at the next period start.
// Backpressure: none, free-running; PULSE_SEQ_CPMG_EN builds the multi-echo (ECHO) path.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int MIN_PER = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PER_W-1:0]  per,
    input  logic [T_W-1:0]    p1wid,
    input  logic [T_W-1:0]    del,
    input  logic [T_W-1:0]    p2wid,
    input  logic [CP_W-1:0]   cp,
    input  logic [7:0]        p_bl,
    input  logic              bl,
    input  logic              rxd,
    output logic              pulse,
    output logic              blank,
    output logic              sync,
    output logic              busy
);

    localparam logic [PER_W-1:0] MIN_PER_V = PER_W'(MIN_PER);

    logic [PER_W-1:0] per_sh;
    logic [T_W-1:0]   p1_sh, del_sh, p2_sh;
    logic [CP_W-1:0]  cp_sh;
    logic [7:0]       pbl_sh;
    logic             bl_sh;

    logic             rxd_q, upd_pend, run, wrap;
    logic [PER_W-1:0] pcnt, per_s;

    seq_state_t       state, st_n;
    logic             tmr_ld, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic             go_p1, go_ap1, go_gap, go_p2, go_ap2, go_hold;
`ifdef PULSE_SEQ_CPMG_EN
    logic [CP_W-1:0]  rc, rc_n;
    logic [CP_W:0]    rc_inc;
    logic             go_echo;
`endif

    assign per_s = (per_sh < MIN_PER_V) ? MIN_PER_V : per_sh;
    assign wrap  = run && (pcnt == per_s - 1'b1);

    // Only an edge seen before the wrap edge counts; one landing on it waits a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q    <= 1'b0;
            upd_pend <= 1'b0;
            run      <= 1'b0;
            pcnt     <= '0;
            sync     <= 1'b0;
        end else begin
            rxd_q <= rxd;
            run   <= 1'b1;
            sync  <= !run || wrap;
            if (rxd && !rxd_q) begin
                upd_pend <= 1'b1;
            end else if (wrap) begin
                upd_pend <= 1'b0;
            end
            if (wrap) begin
                pcnt <= '0;
            end else if (run) begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh <= PER_RST;
            p1_sh  <= P1WID_RST;
            del_sh <= DEL_RST;
            p2_sh  <= P2WID_RST;
            cp_sh  <= CP_RST;
            pbl_sh <= PBL_RST;
            bl_sh  <= BL_RST;
        end else if (wrap && upd_pend) begin
            per_sh <= per;
            p1_sh  <= p1wid;
            del_sh <= del;
            p2_sh  <= p2wid;
            cp_sh  <= cp;
            pbl_sh <= p_bl;
            bl_sh  <= bl;
        end
    end

    seq_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_ld),
        .val   (tmr_val),
        .done  (tmr_done)
    );

    // Entry requests cascade in sequence order so zero-length segments fall through in one cycle.
    always_comb begin
        st_n    = state;
        tmr_ld  = 1'b0;
        tmr_val = '0;
        go_p1   = 1'b0;
        go_ap1  = 1'b0;
        go_gap  = 1'b0;
        go_p2   = 1'b0;
        go_ap2  = 1'b0;
        go_hold = 1'b0;
`ifdef PULSE_SEQ_CPMG_EN
        rc_n    = rc;
        rc_inc  = '0;
        go_echo = 1'b0;
`endif
        if (!run || wrap) begin
            st_n = IDLE;
        end else if (pcnt == '0) begin
            go_p1 = 1'b1;
        end else if (tmr_done) begin
            case (state)
                P1:      go_ap1 = 1'b1;
                GAP:     go_p2  = 1'b1;
                P2:      go_ap2 = 1'b1;
`ifdef PULSE_SEQ_CPMG_EN
                ECHO:    go_p2  = 1'b1;
`endif
                HOLD:    st_n   = TAIL;
                default: st_n   = state;
            endcase
        end

        if (go_p1) begin
`ifdef PULSE_SEQ_CPMG_EN
            rc_n = '0;
`endif
            if (p1_sh != '0) begin
                st_n = P1; tmr_ld = 1'b1; tmr_val = TMR_W'(p1_sh);
            end else begin
                go_ap1 = 1'b1;
            end
        end
        if (go_ap1) begin
            if (cp_sh == '0) go_hold = 1'b1;
            else             go_gap  = 1'b1;
        end
        if (go_gap) begin
            if (del_sh != '0) begin
                st_n = GAP; tmr_ld = 1'b1; tmr_val = TMR_W'(del_sh);
            end else begin
                go_p2 = 1'b1;
            end
        end
        if (go_p2) begin
            if (p2_sh != '0) begin
                st_n = P2; tmr_ld = 1'b1; tmr_val = TMR_W'(p2_sh);
            end else begin
                go_ap2 = 1'b1;
            end
        end
`ifdef PULSE_SEQ_CPMG_EN
        if (go_ap2) begin
            rc_inc = {1'b0, rc_n} + 1'b1;
            rc_n   = rc_inc[CP_W-1:0];
            if (rc_inc < {1'b0, cp_sh}) go_echo = 1'b1;
            else                        go_hold = 1'b1;
        end
        if (go_echo) begin
            if (del_sh != '0) begin
                st_n = ECHO; tmr_ld = 1'b1; tmr_val = {del_sh, 1'b0};
            end else if (p2_sh != '0) begin
                st_n = P2; tmr_ld = 1'b1; tmr_val = TMR_W'(p2_sh);
            end else begin
                go_hold = 1'b1;
            end
        end
`else
        if (go_ap2) begin
            go_hold = 1'b1;
        end
`endif
        if (go_hold) begin
            if (pbl_sh != '0) begin
                st_n = HOLD; tmr_ld = 1'b1; tmr_val = TMR_W'(pbl_sh);
            end else begin
                st_n = TAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pulse <= 1'b0;
            blank <= 1'b0;
            busy  <= 1'b0;
`ifdef PULSE_SEQ_CPMG_EN
            rc    <= '0;
`endif
        end else begin
            state <= st_n;
            pulse <= (st_n == P1) || (st_n == P2);
            busy  <= (st_n != IDLE) && (st_n != TAIL);
            blank <= bl_sh && (st_n != IDLE) && (st_n != TAIL);
`ifdef PULSE_SEQ_CPMG_EN
            rc    <= rc_n;
`endif
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
`timescale 1ns/1ps
module tb_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid;
    logic [7:0]  cp, p_bl;
    logic        bl, rxd;
    logic        pulse, blank, sync, busy;

    int total = 0;
    int bad   = 0;
    int rel   = 0;

`ifdef PULSE_SEQ_CPMG_EN
    localparam logic CPMG = 1'b1;
`else
    localparam logic CPMG = 1'b0;
`endif

    pulse_sequencer #(.MIN_PER(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .per   (per),
        .p1wid (p1wid),
        .del   (del),
        .p2wid (p2wid),
        .cp    (cp),
        .p_bl  (p_bl),
        .bl    (bl),
        .rxd   (rxd),
        .pulse (pulse),
        .blank (blank),
        .sync  (sync),
        .busy  (busy)
    );

    always #2.4875 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int target);
        while (rel < target) tick();
    endtask

    task automatic wait_sync(input string tag, input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (sync === 1'b1) found = 1'b1;
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL %s: sync observed=0 expected=1 within %0d cycles", tag, bound);
        end
        rel = 0;
    endtask

    task automatic strobe_rxd();
        rxd = 1'b1;
        tick();
        rxd = 1'b0;
    endtask

    task automatic set_params(input logic [31:0] a_per, input logic [15:0] a_p1, input logic [15:0] a_del,
                              input logic [15:0] a_p2, input logic [7:0] a_cp, input logic [7:0] a_pbl,
                              input logic a_bl);
        per = a_per; p1wid = a_p1; del = a_del; p2wid = a_p2; cp = a_cp; p_bl = a_pbl; bl = a_bl;
    endtask

    initial begin
        int act;
        int nsync;
        rst_n = 1'b0;
        rxd   = 1'b0;
        set_params(32'd10000, 16'd40, 16'd150, 16'd40, 8'd1, 8'd100, 1'b1);
        repeat (3) tick();
        chk("rst_pulse", pulse, 0);
        chk("rst_blank", blank, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_sync",  sync,  0);
        rst_n = 1'b1;

        // Power-on defaults.
        wait_sync("first_sync", 5);
        chk("def_t0_pulse", pulse, 0);
        chk("def_t0_busy",  busy,  0);
        adv(1);     chk("def_p1_rise",  pulse, 1); chk("def_blank_rise", blank, 1);
        adv(40);    chk("def_p1_last",  pulse, 1);
        adv(41);    chk("def_gap",      pulse, 0);
        adv(190);   chk("def_gap_last", pulse, 0);
        adv(191);   chk("def_p2_rise",  pulse, 1);
        adv(230);   chk("def_p2_last",  pulse, 1);
        adv(231);   chk("def_p2_fall",  pulse, 0); chk("def_hold_blank", blank, 1);
        adv(330);   chk("def_blank_last", blank, 1);
        adv(331);   chk("def_blank_fall", blank, 0); chk("def_tail_busy", busy, 0);
        adv(9999);  chk("def_sync_pre",  sync, 0);
        adv(10000); chk("def_sync_per",  sync, 1);
        rel = 0;

        // Multi-echo train from the period after the update.
        adv(5);
        set_params(32'd100, 16'd4, 16'd10, 16'd4, 8'd3, 8'd5, 1'b1);
        strobe_rxd();
        wait_sync("cp3_sync", 10100);
        adv(14); chk("cp3_gap_last", pulse, 0);
        adv(15); chk("cp3_p2a_rise", pulse, 1);
        adv(18); chk("cp3_p2a_last", pulse, 1);
        adv(19); chk("cp3_p2a_fall", pulse, 0);
        adv(20); del = 16'd20; strobe_rxd();
        adv(25); del = 16'd7;  strobe_rxd();
        adv(38); chk("cp3_echo_last", pulse, 0);
        adv(39); chk("cp3_p2b_rise",  pulse, CPMG);
        adv(63); chk("cp3_p2c_rise",  pulse, CPMG);
        adv(67); chk("cp3_p2c_fall",  pulse, 0);
        adv(71); chk("cp3_blank_end", blank, CPMG);
        adv(72); chk("cp3_blank_off", blank, 0);
        adv(99); chk("cp3_sync_pre",  sync, 0);
        adv(100); chk("cp3_sync_per", sync, 1);
        rel = 0;

        // Last del value (7) in force; rxd strobed during T0 applies one period later.
        per = 32'd60;
        strobe_rxd();
        adv(11); chk("del7_gap_last", pulse, 0);
        adv(12); chk("del7_p2_rise",  pulse, 1);
        adv(15); chk("del7_p2_last",  pulse, 1);
        adv(16); chk("del7_p2_fall",  pulse, 0);
        adv(20); chk("del7_blank20",  blank, 1);
        adv(21); chk("del7_blank21",  blank, CPMG);
        adv(30); chk("del7_p2b",      pulse, CPMG);
        adv(56); chk("del7_blank56",  blank, CPMG);
        adv(57); chk("del7_blank57",  blank, 0);
        adv(60); chk("t0rxd_old_per", sync, 0);
        adv(100); chk("t0rxd_sync100", sync, 1);
        rel = 0;
        adv(60); chk("t0rxd_new_per", sync, 1);
        rel = 0;

        // Truncation of a long pulse by a short period.
        adv(5);
        set_params(32'd50, 16'd300, 16'd7, 16'd4, 8'd0, 8'd0, 1'b1);
        strobe_rxd();
        wait_sync("trunc_sync", 100);
        adv(1);  chk("trunc_rise",  pulse, 1);
        adv(49); chk("trunc_last",  pulse, 1); chk("trunc_busy", busy, 1);
        adv(50); chk("trunc_drop",  pulse, 0); chk("trunc_sync50", sync, 1);
        adv(51); chk("trunc_restart", pulse, 1);
        per = 32'd1;
        strobe_rxd();

        // per=1 is clamped to a two-cycle period.
        wait_sync("clamp_sync", 60);
        chk("clamp_t0_pulse", pulse, 0);
        adv(1); chk("clamp_sync1", sync, 0); chk("clamp_pulse1", pulse, 1);
        adv(2); chk("clamp_sync2", sync, 1); chk("clamp_pulse2", pulse, 0);

        // rxd seen on the wrap edge: the period just started keeps old shadows.
        adv(3);
        set_params(32'd20, 16'd0, 16'd7, 16'd4, 8'd0, 8'd0, 1'b0);
        strobe_rxd();
        chk("wrap_rxd_t0", sync, 1);
        adv(5); chk("wrap_rxd_old_p1", pulse, 1);
        wait_sync("quiet_sync", 50);
        act   = 0;
        nsync = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pulse !== 1'b0 || blank !== 1'b0 || busy !== 1'b0) act++;
            if (sync === 1'b1) nsync++;
        end
        chk("quiet_outputs",   act,   0);
        chk("quiet_sync_cnt",  nsync, 1);
        chk("quiet_sync_end",  sync,  1);

        // Reset asserted in the middle of P2.
        set_params(32'd100, 16'd4, 16'd10, 16'd20, 8'd1, 8'd5, 1'b1);
        strobe_rxd();
        wait_sync("p2rst_sync", 50);
        adv(20);
        chk("p2rst_pre_pulse", pulse, 1);
        chk("p2rst_pre_blank", blank, 1);
        rst_n = 1'b0;
        #1;
        chk("p2rst_pulse", pulse, 0);
        chk("p2rst_blank", blank, 0);
        chk("p2rst_busy",  busy,  0);
        chk("p2rst_sync",  sync,  0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_sync("post_rst_sync", 5);
        adv(40);  chk("post_rst_p1_last", pulse, 1);
        adv(41);  chk("post_rst_gap",     pulse, 0);
        adv(191); chk("post_rst_p2",      pulse, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
